// File: rtl/conv_kxk_mac.sv
`default_nettype none
// ============================================================================
// conv_kxk_mac : KxK fixed-point convolution MAC with channel accumulation,
//                bias, rounding, saturation and optional ReLU.
// Revision 1.0
// ============================================================================
module conv_kxk_mac #(
   parameter int KERNEL = 3,
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int ACC_W  = 48
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             in_last,
   input  logic [KERNEL*KERNEL*DATA_W-1:0]  im,
   input  logic [KERNEL*KERNEL*DATA_W-1:0]  iw,
   input  logic [DATA_W-1:0]                ib,
   input  logic                             cfg_relu,
   output logic [DATA_W-1:0]                om,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             out_sat
);
   localparam int N  = KERNEL * KERNEL;
   localparam int PW = 2 * DATA_W;

   localparam logic [1:0] c_ST_RUN   = 2'd0;
   localparam logic [1:0] c_ST_DRAIN = 2'd1;
   localparam logic [1:0] c_ST_OUT   = 2'd2;

   localparam logic signed [ACC_W-1:0] c_HALF = {{(ACC_W-1){1'b0}}, 1'b1} <<< (FRAC_W - 1);
   localparam logic signed [ACC_W-1:0] c_MAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] c_MIN  = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic [1:0]              r_state;
   logic                    r_first;
   logic                    r_in_first;
   logic [DATA_W-1:0]       r_bias;
   logic                    r_relu;
   logic                    r_p1_vld;
   logic                    r_p1_last;
   logic signed [PW-1:0]    r_prod [N];
   logic                    r_p2_vld;
   logic                    r_p2_last;
   logic signed [ACC_W-1:0] r_sum;
   logic signed [ACC_W-1:0] r_acc;
   logic [DATA_W-1:0]       r_om;
   logic                    r_out_valid;
   logic                    r_out_sat;

   logic                    w_accept;
   logic signed [PW-1:0]    w_prod [N];
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_bias_sh;
   logic signed [ACC_W-1:0] w_acc_nxt;
   logic signed [ACC_W-1:0] w_rnd;
   logic                    w_sat_hi;
   logic                    w_sat_lo;
   logic [DATA_W-1:0]       w_clamp;
   logic [DATA_W-1:0]       w_om;

   assign in_ready  = (r_state == c_ST_RUN);
   assign w_accept  = in_valid && in_ready;
   assign om        = r_om;
   assign out_valid = r_out_valid;
   assign out_sat   = r_out_sat;

   // Operands are widened to the product width so the multiply is exact.
   for (genvar gi = 0; gi < N; gi++) begin : g_prod
      logic signed [PW-1:0] w_a;
      logic signed [PW-1:0] w_b;
      assign w_a         = {{DATA_W{im[DATA_W*gi+DATA_W-1]}}, im[DATA_W*gi +: DATA_W]};
      assign w_b         = {{DATA_W{iw[DATA_W*gi+DATA_W-1]}}, iw[DATA_W*gi +: DATA_W]};
      assign w_prod[gi]  = w_a * w_b;
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < N; i++) begin
         w_sum = w_sum + {{(ACC_W-PW){r_prod[i][PW-1]}}, r_prod[i]};
      end
   end

   // Bias is aligned to the product scale (2*FRAC_W fractional bits).
   assign w_bias_sh = {{(ACC_W-DATA_W){r_bias[DATA_W-1]}}, r_bias} <<< FRAC_W;
   assign w_acc_nxt = (r_first ? w_bias_sh : r_acc) + r_sum;
   assign w_rnd     = (w_acc_nxt + c_HALF) >>> FRAC_W;
   assign w_sat_hi  = (w_rnd > c_MAX);
   assign w_sat_lo  = (w_rnd < c_MIN);

   always_comb begin
      w_clamp = w_rnd[DATA_W-1:0];
      if (w_sat_hi) begin
         w_clamp = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (w_sat_lo) begin
         w_clamp = {1'b1, {(DATA_W-1){1'b0}}};
      end
      w_om = (r_relu && w_clamp[DATA_W-1]) ? '0 : w_clamp;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_ST_RUN;
         r_first     <= 1'b1;
         r_in_first  <= 1'b1;
         r_bias      <= '0;
         r_relu      <= 1'b0;
         r_p1_vld    <= 1'b0;
         r_p1_last   <= 1'b0;
         for (int i = 0; i < N; i++) begin
            r_prod[i] <= '0;
         end
         r_p2_vld    <= 1'b0;
         r_p2_last   <= 1'b0;
         r_sum       <= '0;
         r_acc       <= '0;
         r_om        <= '0;
         r_out_valid <= 1'b0;
         r_out_sat   <= 1'b0;
      end else begin
         r_p1_vld <= w_accept;
         if (w_accept) begin
            r_prod     <= w_prod;
            r_p1_last  <= in_last;
            r_in_first <= 1'b0;
         end
         if (w_accept && r_in_first) begin
            r_bias <= ib;
            r_relu <= cfg_relu;
         end

         r_p2_vld <= r_p1_vld;
         if (r_p1_vld) begin
            r_sum     <= w_sum;
            r_p2_last <= r_p1_last;
         end

         if (r_p2_vld) begin
            r_acc   <= w_acc_nxt;
            r_first <= 1'b0;
         end

         case (r_state)
            c_ST_RUN: begin
               if (w_accept && in_last) begin
                  r_state <= c_ST_DRAIN;
               end
            end
            c_ST_DRAIN: begin
               if (r_p2_vld && r_p2_last) begin
                  r_om        <= w_om;
                  r_out_sat   <= w_sat_hi || w_sat_lo;
                  r_out_valid <= 1'b1;
                  r_state     <= c_ST_OUT;
               end
            end
            c_ST_OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_first     <= 1'b1;
                  r_in_first  <= 1'b1;
                  r_state     <= c_ST_RUN;
               end
            end
            default: begin
               r_state <= c_ST_RUN;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_kxk_mac.sv
`default_nettype none
// ============================================================================
// tb_conv_kxk_mac : directed bench with an arithmetic reference model.
// Revision 1.0
// ============================================================================
module tb_conv_kxk_mac;
   localparam int K  = 3;
   localparam int DW = 16;
   localparam int FW = 8;
   localparam int AW = 48;
   localparam int N  = K * K;
   localparam int VW = N * DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_last = 1'b0;
   logic [VW-1:0] im = '0;
   logic [VW-1:0] iw = '0;
   logic [DW-1:0] ib = '0;
   logic          cfg_relu = 1'b0;
   logic [DW-1:0] om;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_sat;

   typedef struct {
      logic [DW-1:0] om;
      logic          sat;
   } exp_t;

   exp_t          q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            last_acc_cyc = 0;
   longint        m_acc = 0;
   bit            m_first = 1'b1;
   bit            m_relu = 1'b0;
   logic [DW-1:0] seen_om = '0;
   logic          seen_sat = 1'b0;
   bit            prev_ov = 1'b0;

   conv_kxk_mac #(.KERNEL(K), .DATA_W(DW), .FRAC_W(FW), .ACC_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .im        (im),
      .iw        (iw),
      .ib        (ib),
      .cfg_relu  (cfg_relu),
      .om        (om),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [VW-1:0] fill(input logic [DW-1:0] v);
      logic [VW-1:0] r;
      for (int i = 0; i < N; i++) r[DW*i +: DW] = v;
      return r;
   endfunction

   function automatic logic [VW-1:0] ramp(input logic [DW-1:0] step);
      logic [VW-1:0] r;
      for (int i = 0; i < N; i++) r[DW*i +: DW] = DW'(step * (i + 1));
      return r;
   endfunction

   // Real-valued pixel: bias*2^FW + sum(products), round half up, clamp, ReLU.
   task automatic push_expect();
      longint r;
      exp_t   e;
      r     = (m_acc + (longint'(1) <<< (FW - 1))) >>> FW;
      e.sat = 1'b0;
      if (r > 32767) begin
         r = 32767;
         e.sat = 1'b1;
      end else if (r < -32768) begin
         r = -32768;
         e.sat = 1'b1;
      end
      e.om = (m_relu && r < 0) ? '0 : r[DW-1:0];
      q.push_back(e);
   endtask

   task automatic send(input logic [VW-1:0] vim, input logic [VW-1:0] viw,
                       input logic [DW-1:0] vb, input logic relu, input logic last);
      logic rdy;
      int   n;
      n = 0;
      im = vim; iw = viw; ib = vb; cfg_relu = relu; in_last = last; in_valid = 1'b1;
      do begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 100);
      if (!rdy) begin
         chk("accept_timeout", {63'd0, rdy}, 64'd1);
         return;
      end
      if (m_first) begin
         m_acc   = longint'($signed(vb)) * (longint'(1) <<< FW);
         m_relu  = relu;
         m_first = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         m_acc += longint'($signed(vim[DW*i +: DW])) * longint'($signed(viw[DW*i +: DW]));
      end
      if (last) begin
         push_expect();
         m_first      = 1'b1;
         last_acc_cyc = cyc;
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_timeout", 64'(q.size()), 64'd0);
   endtask

   task automatic pixel_lit(input string name, input logic [DW-1:0] exp_om, input logic exp_sat);
      wait_drain();
      chk({name, "_om"}, 64'(seen_om), 64'(exp_om));
      chk({name, "_sat"}, {63'd0, seen_sat}, {63'd0, exp_sat});
   endtask

   // Output checker: every cycle out_valid is high, om/out_sat must match the model.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid) begin
            chk("in_ready_low_while_out", {63'd0, in_ready}, 64'd0);
            if (q.size() == 0) begin
               chk("unexpected_output", {63'd0, out_valid}, 64'd0);
            end else begin
               chk("om", 64'(om), 64'(q[0].om));
               chk("out_sat", {63'd0, out_sat}, {63'd0, q[0].sat});
               if (!prev_ov) chk("latency", 64'(cyc), 64'(last_acc_cyc + 2));
               if (out_ready) begin
                  seen_om  = om;
                  seen_sat = out_sat;
                  void'(q.pop_front());
               end
            end
         end
         prev_ov = out_valid;
      end
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_om", 64'(om), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_sat", {63'd0, out_sat}, 64'd0);

      send(fill(16'h0100), fill(16'h0100), 16'h0000, 1'b0, 1'b1);
      idle();
      pixel_lit("unit", 16'h0900, 1'b0);

      send(fill(16'h0100), fill(16'h0100), 16'h0080, 1'b0, 1'b1);
      idle();
      pixel_lit("bias", 16'h0980, 1'b0);

      for (int c = 0; c < 4; c++) begin
         send(fill(16'h0100), fill(16'h0100), 16'h0000, 1'b0, (c == 3));
      end
      idle();
      chk("in_ready_after_last", {63'd0, in_ready}, 64'd0);
      pixel_lit("four_ch", 16'h2400, 1'b0);

      send(fill(16'h0100), fill(16'hFF00), 16'h0000, 1'b0, 1'b1);
      idle();
      pixel_lit("neg", 16'hF700, 1'b0);
      send(fill(16'h0100), fill(16'hFF00), 16'h0000, 1'b1, 1'b1);
      idle();
      pixel_lit("neg_relu", 16'h0000, 1'b0);

      send(fill(16'h7FFF), fill(16'h7FFF), 16'h0000, 1'b0, 1'b1);
      idle();
      pixel_lit("sat_hi", 16'h7FFF, 1'b1);
      send(fill(16'h7FFF), fill(16'h8000), 16'h0000, 1'b0, 1'b1);
      idle();
      pixel_lit("sat_lo", 16'h8000, 1'b1);
      send(fill(16'h7FFF), fill(16'h8000), 16'h0000, 1'b1, 1'b1);
      idle();
      pixel_lit("sat_lo_relu", 16'h0000, 1'b1);

      // Half-LSB ties: +4.5 -> 5, -4.5 -> -4.
      send(fill(16'h0001), fill(16'h0080), 16'h0000, 1'b0, 1'b1);
      idle();
      pixel_lit("round_pos", 16'h0005, 1'b0);
      send(fill(16'h0001), fill(16'hFF80), 16'h0000, 1'b0, 1'b1);
      idle();
      pixel_lit("round_neg", 16'hFFFC, 1'b0);
      send(ramp(16'h0100), fill(16'h0080), 16'hFF80, 1'b0, 1'b1);
      idle();
      pixel_lit("ramp", 16'h1600, 1'b0);

      // Backpressure.
      out_ready = 1'b0;
      send(fill(16'h0100), fill(16'h0100), 16'h0000, 1'b0, 1'b1);
      idle();
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("bp_out_valid_rise", {63'd0, out_valid}, 64'd1);
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_hold_om", 64'(om), 64'h0900);
         chk("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
      chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
      pixel_lit("bp", 16'h0900, 1'b0);

      // Back-to-back pixels; ib and cfg_relu on non-first pairs must be ignored.
      send(fill(16'h0100), fill(16'h0100), 16'h0100, 1'b0, 1'b0);
      send(fill(16'h0100), fill(16'h0100), 16'h7F00, 1'b1, 1'b1);
      send(fill(16'h0100), fill(16'hFF00), 16'h0000, 1'b1, 1'b1);
      send(fill(16'h0100), fill(16'h0100), 16'h0080, 1'b0, 1'b1);
      idle();
      pixel_lit("b2b_last", 16'h0980, 1'b0);

      // Reset mid-pixel.
      send(fill(16'h0100), fill(16'h0100), 16'h0100, 1'b0, 1'b0);
      send(fill(16'h0100), fill(16'h0100), 16'h0100, 1'b0, 1'b0);
      idle();
      rst_n = 1'b0;
      m_first = 1'b1;
      #1;
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(fill(16'h0100), fill(16'h0100), 16'h0000, 1'b0, 1'b1);
      idle();
      pixel_lit("after_rst", 16'h0900, 1'b0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/conv_kxk_mac.md
Name: conv_kxk_mac

Overview:
- Parametrised fixed-point KxK convolution engine; successor to the single-shot 3x3/1x1 conv units.
- Accepts a stream of KxK input windows and weight windows, one per input channel, through a valid/ready handshake.
- Multiplies element-wise, reduces each window with a pipelined adder tree and accumulates across channels until the last window.
- Then adds bias, rounds, saturates, applies optional ReLU and presents one output pixel per valid/ready handshake.

Parameters:
- KERNEL, 3: kernel side; window holds KERNEL*KERNEL elements (KERNEL=1 must work).
- DATA_W, 16: signed fixed-point width of im, iw, ib, om.
- FRAC_W, 8: fractional bits of im, iw, ib, om (Q(DATA_W-FRAC_W).FRAC_W).
- ACC_W, 48: accumulator width; must be >= 2*DATA_W + clog2(KERNEL*KERNEL) + 10.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  window/weight pair available.
- in_ready  out  1  engine accepts a pair this cycle.
- in_last  in  1  accepted pair is the last input channel of the pixel.
- im  in  KERNEL*KERNEL*DATA_W  input window, element i at bits [DATA_W*i +: DATA_W].
- iw  in  KERNEL*KERNEL*DATA_W  weight window, same packing.
- ib  in  DATA_W  bias; sampled with the first pair of each pixel.
- cfg_relu  in  1  ReLU enable; sampled with the first pair of each pixel.
- om  out  DATA_W  output pixel.
- out_valid  out  1  om valid.
- out_ready  in  1  consumer takes om.
- out_sat  out  1  om was saturated; qualified by out_valid.

Behaviour:
- Reset (async, rst_n=0): all pipeline valids = 0, state = RUN, first = 1, acc = 0, om = 0, out_valid = 0, out_sat = 0. in_ready = 1 after reset is released.
- Reset mid-pixel discards all partial sums; no output is produced for that pixel.
- Accept: a pair is accepted when in_valid && in_ready at a rising edge.
- FSM:
  - RUN: in_ready = 1. Accepting a pair with in_last=1 moves to DRAIN.
  - DRAIN: in_ready = 0. Waits until the last pair's sum updates the accumulator, then moves to OUT.
  - OUT: in_ready = 0, out_valid = 1. om and out_sat are held stable until out_ready=1; that edge clears out_valid and returns to RUN.
- Pipeline:
  - P1 (accept edge): register signed products prod[i] = im[i]*iw[i], each 2*DATA_W bits wide, plus the last flag.
  - P2 (next edge): register the sum of all products, sign-extended to ACC_W.
  - ACC (next edge): on the first pair of a pixel, acc = (sext(ib) << FRAC_W) + sum; otherwise acc = acc + sum. first is cleared after the first pair and set again when OUT hands off.
- Latency: out_valid rises at the 2nd rising edge after the accept edge of the in_last pair. om is registered on that same edge from the final acc value, computed combinationally. A C-channel pixel therefore costs C + 2 cycles plus the output handshake.
- Output arithmetic:
  - r = (acc + 2^(FRAC_W-1)) >>> FRAC_W (arithmetic shift, round half up).
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_sat = 1 if clamped.
  - If the sampled cfg_relu = 1 and the saturated r < 0, om = 0. out_sat keeps its clamp value.
- Single-channel pixel: first and last on the same pair is legal.
- in_last=1 on a pair arriving while in_ready=0 is ignored; no acceptance occurs.
- ib and cfg_relu changes mid-pixel are ignored.
- No overflow detection on acc; ACC_W sizing guarantees no wrap for up to 1024 channels.

Test Plan:
- K=3, Q8.8: one pair, all im=0x0100, all iw=0x0100, ib=0, in_last=1 -> om=0x0900, out_sat=0; out_valid rises 2 edges after accept.
- Same stimulus with ib=0x0080 -> om=0x0980. Then 4 pairs (in_last on the 4th), ib=0 -> om=0x2400; in_ready low from the edge after the 4th accept until out_ready.
- iw all 0xFF00 (-1.0), im all 0x0100, ib=0: cfg_relu=0 -> om=0xF700; cfg_relu=1 -> om=0x0000.
- im=iw=all 0x7FFF -> om=0x7FFF, out_sat=1. im=0x7FFF, iw=0x8000 -> om=0x8000, out_sat=1; with relu -> om=0x0000, out_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles -> om, out_valid, out_sat stable and in_ready=0 throughout. Release -> out_valid falls, in_ready=1 next cycle. Back-to-back pixels with in_valid held high yield correct independent results (first flag resets, bias re-sampled).
- Assert rst_n=0 after 2 of 4 pairs are accepted -> out_valid=0 immediately. After release, a fresh 1-pair pixel gives om=0x0900 with no residue from the aborted pixel.
